morse_tx_controller: RTL

- Sequencer between the UART receive FIFO and the Morse output (LED/buzzer pin).
- Pops one received ASCII byte at a time and decodes it to a dot/dash pattern.
- Times marks and gaps in multiples of a programmable unit, then returns for the next byte.
- Exposes the character being keyed so the 7-segment display can show it.

---
 rtl/morse_tx_controller.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/morse_tx_controller.sv
// Morse keying sequencer: pops ASCII bytes from a first-word-fall-through FIFO and keys
// them as ITU Morse marks and gaps timed in multiples of UNIT_TICKS clock cycles.
module morse_tx_controller #(
    parameter int WORD_BITS  = 8,
    parameter int UNIT_TICKS = 6000000,
    parameter int CNT_BITS   = $clog2(4*UNIT_TICKS+1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 fifo_empty_i,
    input  logic [WORD_BITS-1:0] fifo_data_i,
    output logic                 fifo_rd_o,
    output logic                 morse_o,
    output logic                 busy_o,
    output logic                 char_done_o,
    output logic                 unsupported_o,
    output logic [WORD_BITS-1:0] cur_char_o
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        MARK       = 3'd2,
        ELEM_GAP   = 3'd3,
        LETTER_GAP = 3'd4,
        WORD_GAP   = 3'd5
    } state_t;

    localparam logic [CNT_BITS-1:0] DOT_LAST  = CNT_BITS'(UNIT_TICKS - 1);
    localparam logic [CNT_BITS-1:0] DASH_LAST = CNT_BITS'(3*UNIT_TICKS - 1);
    localparam logic [CNT_BITS-1:0] WORD_LAST = CNT_BITS'(4*UNIT_TICKS - 1);

    // Returns {length[2:0], pattern[4:0]}; pattern is left-aligned (bit 4 = first element, 1 = dash).
    // A length of zero marks a byte with no Morse code.
    function automatic logic [7:0] morse_decode(input logic [7:0] ch);
        logic [7:0] up;
        logic [7:0] res;
        logic [3:0] d;
        res = 8'h00;
        d   = 4'h0;
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            up = ch - 8'h20;
        end else begin
            up = ch;
        end
        if (up >= 8'h30 && up <= 8'h39) begin
            d = up[3:0];
            if (d <= 4'd5) begin
                res = {3'd5, 5'b11111 >> d};
            end else begin
                res = {3'd5, ~(5'b11111 >> (d - 4'd5))};
            end
        end else begin
            case (up)
                8'h41: res = {3'd2, 5'b01000};
                8'h42: res = {3'd4, 5'b10000};
                8'h43: res = {3'd4, 5'b10100};
                8'h44: res = {3'd3, 5'b10000};
                8'h45: res = {3'd1, 5'b00000};
                8'h46: res = {3'd4, 5'b00100};
                8'h47: res = {3'd3, 5'b11000};
                8'h48: res = {3'd4, 5'b00000};
                8'h49: res = {3'd2, 5'b00000};
                8'h4A: res = {3'd4, 5'b01110};
                8'h4B: res = {3'd3, 5'b10100};
                8'h4C: res = {3'd4, 5'b01000};
                8'h4D: res = {3'd2, 5'b11000};
                8'h4E: res = {3'd2, 5'b10000};
                8'h4F: res = {3'd3, 5'b11100};
                8'h50: res = {3'd4, 5'b01100};
                8'h51: res = {3'd4, 5'b11010};
                8'h52: res = {3'd3, 5'b01000};
                8'h53: res = {3'd3, 5'b00000};
                8'h54: res = {3'd1, 5'b10000};
                8'h55: res = {3'd3, 5'b00100};
                8'h56: res = {3'd4, 5'b00010};
                8'h57: res = {3'd3, 5'b01100};
                8'h58: res = {3'd4, 5'b10010};
                8'h59: res = {3'd4, 5'b10110};
                8'h5A: res = {3'd4, 5'b11000};
                default: res = 8'h00;
            endcase
        end
        return res;
    endfunction

    state_t                 state_r, state_next_s;
    logic [CNT_BITS-1:0]    timer_r, timer_next_s, mark_last_s;
    logic [2:0]             elem_r, elem_next_s, len_r;
    logic [4:0]             pat_r;
    logic [WORD_BITS-1:0]   char_r, cur_char_r;
    logic                   morse_r, busy_r, done_r, unsup_r;
    logic                   done_next_s, unsup_next_s, rd_s, ascii_ok_s, is_space_s;
    logic [7:0]             code_s;

    assign rd_s        = (state_r == IDLE) & enable_i & ~fifo_empty_i & ~reset_i;
    // Bytes wider than ASCII are only decoded when their upper bits are clear.
    assign ascii_ok_s  = (char_r == WORD_BITS'(char_r[7:0]));
    assign is_space_s  = ascii_ok_s && (char_r[7:0] == 8'h20);
    assign code_s      = morse_decode(char_r[7:0]);
    assign mark_last_s = pat_r[3'd4 - elem_r] ? DASH_LAST : DOT_LAST;

    // Next-state, timer and element-index logic.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r + CNT_BITS'(1);
        elem_next_s  = elem_r;
        unsup_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                timer_next_s = '0;
                elem_next_s  = 3'd0;
                if (rd_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                timer_next_s = '0;
                elem_next_s  = 3'd0;
                if (is_space_s) begin
                    state_next_s = WORD_GAP;
                end else if (ascii_ok_s && code_s[7:5] != 3'd0) begin
                    state_next_s = MARK;
                end else begin
                    state_next_s = IDLE;
                    unsup_next_s = 1'b1;
                end
            end
            MARK: begin
                if (timer_r == mark_last_s) begin
                    timer_next_s = '0;
                    if (elem_r == len_r - 3'd1) begin
                        state_next_s = LETTER_GAP;
                    end else begin
                        state_next_s = ELEM_GAP;
                    end
                end else begin
                    state_next_s = MARK;
                end
            end
            ELEM_GAP: begin
                if (timer_r == DOT_LAST) begin
                    timer_next_s = '0;
                    elem_next_s  = elem_r + 3'd1;
                    state_next_s = MARK;
                end else begin
                    state_next_s = ELEM_GAP;
                end
            end
            LETTER_GAP: begin
                if (timer_r == DASH_LAST) begin
                    timer_next_s = '0;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LETTER_GAP;
                end
            end
            WORD_GAP: begin
                if (timer_r == WORD_LAST) begin
                    timer_next_s = '0;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WORD_GAP;
                end
            end
            default: begin
                timer_next_s = '0;
                elem_next_s  = 3'd0;
                state_next_s = IDLE;
            end
        endcase
        // Registered done must land on the final gap cycle, so look one cycle ahead.
        done_next_s = unsup_next_s
                    | ((state_next_s == LETTER_GAP) && (timer_next_s == DASH_LAST))
                    | ((state_next_s == WORD_GAP)   && (timer_next_s == WORD_LAST));
    end

    // State, timer, latched character/code and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            timer_r    <= '0;
            elem_r     <= 3'd0;
            len_r      <= 3'd0;
            pat_r      <= 5'd0;
            char_r     <= '0;
            cur_char_r <= '0;
            morse_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            unsup_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
            elem_r  <= elem_next_s;
            morse_r <= (state_next_s == MARK);
            busy_r  <= (state_next_s != IDLE);
            done_r  <= done_next_s;
            unsup_r <= unsup_next_s;
            if (rd_s) begin
                char_r     <= fifo_data_i;
                cur_char_r <= fifo_data_i;
            end
            if (state_r == LOAD) begin
                len_r <= code_s[7:5];
                pat_r <= code_s[4:0];
            end
        end
    end

    assign fifo_rd_o     = rd_s;
    assign morse_o       = morse_r;
    assign busy_o        = busy_r;
    assign char_done_o   = done_r;
    assign unsupported_o = unsup_r;
    assign cur_char_o    = cur_char_r;
endmodule
